// File: rtl/regbank_lock_pkg.sv
// Shared definitions for the lock-protected register bank controller:
// op encodings, FSM states and the command rejection rule.
package regbank_lock_pkg;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_LOCK  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } st_e;

  // A command is rejected for an out-of-range address, or a write to a locked register.
  function automatic logic lock_err(input int unsigned addr, input int unsigned num_regs,
                                    input logic op, input logic locked);
    return (addr >= num_regs) || ((op == OP_WRITE) && locked);
  endfunction

endpackage

// File: rtl/regbank_lock_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last winner.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_s;
  logic [N-1:0]  gnt_s;
  logic          found_s;
  logic          hit_s;

  // Scan candidates in rotating order from the pointer; first requester found wins.
  always_comb begin
    gnt_s   = {N{1'b0}};
    win_s   = {PW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int j = 0; j < N; j++) begin
        hit_s    = !found_s && req[j] && (((int'(ptr_r) + off) % N) == j);
        gnt_s[j] = gnt_s[j] | hit_s;
        win_s    = hit_s ? PW'(j) : win_s;
        found_s  = found_s | hit_s;
      end
    end
  end

  // Pointer moves to the requester after the winner whenever a grant is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (advance) begin
      ptr_r <= (win_s == PW'(N - 1)) ? {PW{1'b0}} : (win_s + PW'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/regbank_lock_arbiter.sv
// Write controller for a lock-protected register bank: arbitrates requesters,
// checks the per-register sticky lock and commits accepted writes/locks.
module regbank_lock_arbiter
  import regbank_lock_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic                       resp_valid,
  output logic [IDW-1:0]             resp_id,
  output logic                       resp_err,
  output logic [NUM_REGS*DATA_W-1:0] reg_bank,
  output logic [NUM_REGS-1:0]        lock_status
);

  st_e                       state_r;
  st_e                       state_nxt_s;
  logic [NUM_REQ-1:0]        gnt_s;
  logic                      advance_s;
  logic [IDW-1:0]            win_id_s;
  logic                      op_sel_s;
  logic [ADDR_W-1:0]         addr_sel_s;
  logic [DATA_W-1:0]         wdata_sel_s;
  logic [IDW-1:0]            id_r;
  logic                      op_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [DATA_W-1:0]         wdata_r;
  logic                      err_r;
  logic                      lock_sel_s;
  logic [NUM_REGS*DATA_W-1:0] bank_r;
  logic [NUM_REGS-1:0]       lock_r;
  logic                      resp_valid_r;
  logic [IDW-1:0]            resp_id_r;
  logic                      resp_err_r;

  // Grants are only taken in IDLE outside reset so a reset cycle never accepts a command.
  assign advance_s = rst_n && (state_r == ST_IDLE) && (|req_valid);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance_s),
    .gnt     (gnt_s)
  );

  // Ready mirrors the grant, gated to the accepting IDLE cycle.
  always_comb begin
    req_ready = advance_s ? gnt_s : {NUM_REQ{1'b0}};
  end

  // One-hot mux of the winning requester's command fields.
  always_comb begin
    win_id_s    = {IDW{1'b0}};
    op_sel_s    = 1'b0;
    addr_sel_s  = {ADDR_W{1'b0}};
    wdata_sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      win_id_s    = gnt_s[i] ? IDW'(i) : win_id_s;
      op_sel_s    = op_sel_s | (gnt_s[i] & req_op[i]);
      addr_sel_s  = addr_sel_s | ({ADDR_W{gnt_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
      wdata_sel_s = wdata_sel_s | ({DATA_W{gnt_s[i]}} & req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  // Lock bit of the latched address; out-of-range addresses select nothing.
  always_comb begin
    lock_sel_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      lock_sel_s = lock_sel_s | (lock_r[i] & (32'(addr_r) == 32'(i)));
    end
  end

  // Next-state logic: fixed four-step walk once a command is accepted.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_nxt_s = advance_s ? ST_CHECK : ST_IDLE;
      ST_CHECK:  state_nxt_s = ST_COMMIT;
      ST_COMMIT: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the winning command; it is held until the response regardless of req_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_r    <= {IDW{1'b0}};
      op_r    <= OP_WRITE;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (advance_s) begin
      id_r    <= win_id_s;
      op_r    <= op_sel_s;
      addr_r  <= addr_sel_s;
      wdata_r <= wdata_sel_s;
    end else begin
      id_r    <= id_r;
      op_r    <= op_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Registered rejection decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state_r == ST_CHECK) begin
      err_r <= lock_err(32'(addr_r), 32'(NUM_REGS), op_r, lock_sel_s);
    end else begin
      err_r <= err_r;
    end
  end

  // Bank and sticky lock storage; this is the only write path into the bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_r <= {(NUM_REGS*DATA_W){1'b0}};
      lock_r <= {NUM_REGS{1'b0}};
    end else if ((state_r == ST_COMMIT) && !err_r) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(addr_r) == 32'(i)) begin
          if (op_r == OP_WRITE) begin
            bank_r[i*DATA_W +: DATA_W] <= wdata_r;
          end else begin
            lock_r[i] <= 1'b1;
          end
        end else begin
          bank_r[i*DATA_W +: DATA_W] <= bank_r[i*DATA_W +: DATA_W];
        end
      end
    end else begin
      bank_r <= bank_r;
      lock_r <= lock_r;
    end
  end

  // Response strobe for the RESP cycle; id/err forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= {IDW{1'b0}};
      resp_err_r   <= 1'b0;
    end else if (state_r == ST_COMMIT) begin
      resp_valid_r <= 1'b1;
      resp_id_r    <= id_r;
      resp_err_r   <= err_r;
    end else begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= {IDW{1'b0}};
      resp_err_r   <= 1'b0;
    end
  end

  assign resp_valid  = resp_valid_r;
  assign resp_id     = resp_id_r;
  assign resp_err    = resp_err_r;
  assign reg_bank    = bank_r;
  assign lock_status = lock_r;

endmodule

// File: doc/regbank_lock_arbiter.md
# regbank_lock_arbiter

Write controller for a lock-protected register bank shared by several requesters. It arbitrates write and lock commands round-robin, applies one uniform per-register lock policy (every register is guarded only by its own sticky lock bit), and commits accepted writes to the bank. It returns a per-command response with an error flag. It sits between the bus-side requesters and the storage, so no path can write the bank except through this lock check.

## Interface
- NUM_REQ, 2: number of requesters.
- NUM_REGS, 4: bank depth.
- DATA_W, 32: register width.
- ADDR_W, 2: address width; addresses >= NUM_REGS are illegal.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational in IDLE.
- req_op  in  NUM_REQ  per-requester op: 0 = WRITE, 1 = LOCK.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address, packed.
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data, packed.
- resp_valid  out  1  one-cycle response strobe.
- resp_id  out  clog2(NUM_REQ) (min 1)  requester that owns the response.
- resp_err  out  1  command rejected.
- reg_bank  out  NUM_REGS*DATA_W  bank contents, register i at bits [i*DATA_W +: DATA_W].
- lock_status  out  NUM_REGS  sticky lock bits.

## Operation
- FSM states are IDLE, CHECK, COMMIT, RESP. Transitions are IDLE->CHECK, CHECK->COMMIT, COMMIT->RESP, RESP->IDLE.
- IDLE: if any req_valid is set, the round-robin arbiter picks a winner and req_ready[winner]=1 in that cycle. On the clock edge the controller latches id, op, addr and wdata, then goes to CHECK. req_ready is 0 in every other state.
- Round-robin: priority starts at the requester after the last winner. After reset, requester 0 has highest priority.
- CHECK: err = (addr >= NUM_REGS) | (op==WRITE & lock_status[addr]). The err value is registered.
- COMMIT, when !err:
  - WRITE sets reg_bank[addr] to wdata.
  - LOCK sets lock_status[addr] to 1.
  - Locking an already-locked register is legal, has no error and causes no change.
- COMMIT, when err: no state change.
- RESP: resp_valid=1 for exactly one cycle, with resp_id and resp_err held. resp_id and resp_err are don't-care when resp_valid=0 but are driven to 0.
- Lock bits are sticky. Only rst_n clears them; no unlock path exists.
- A requester that deasserts req_valid before it is granted is simply not served. Once a command is latched, it completes regardless of later req_valid changes.

## Timing
- Reset values:
  - state = IDLE
  - reg_bank = 0
  - lock_status = 0
  - resp_valid = 0, resp_id = 0, resp_err = 0
  - req_ready = 0 during the reset cycle
  - RR pointer gives priority to requester 0
- Latency: command accepted at edge T (end of IDLE cycle). reg_bank and lock_status update at the edge ending COMMIT, and are visible in cycle T+3. resp_valid is high in cycle T+3.
- Throughput: one command per 4 cycles. The next grant can occur in the cycle after RESP.
- Simultaneous valids: exactly one grant per IDLE cycle. Losers hold their request and are served in later rounds.
- Reset mid-operation: rst_n low on any edge discards the in-flight command. No response is issued, and any write not yet committed is lost.

## Structure
- Package regbank_lock_pkg holds:
  - op constants OP_WRITE and OP_LOCK;
  - state enum st_e (ST_IDLE, ST_CHECK, ST_COMMIT, ST_RESP);
  - an error-check function shared with the bench model.
- One sub-module, rr_arbiter: parameter N, inputs req[N] and advance, output one-hot gnt[N], with a synchronous active-low reset on the pointer.
- The top level holds the FSM, the latched command, the bank and the lock registers.

## Test plan
- Reset, then requester 0 issues WRITE addr 2 data 0xDEADBEEF -> req_ready[0]=1 in cycle 0; resp_valid=1, resp_id=0, resp_err=0 at cycle 3; reg_bank[2]=0xDEADBEEF.
- LOCK addr 1, then WRITE addr 1 data 0x1234 -> lock_status=4'b0010; the write gets resp_err=1 and reg_bank[1] is unchanged (0). A WRITE to addr 0 still succeeds.
- Both requesters hold valid continuously with WRITEs -> grants alternate 0,1,0,1; resp_id follows the same sequence; one response per 4 cycles.
- LOCK addr 3 twice -> both responses have err=0; lock_status[3] stays 1. With NUM_REGS=3, WRITE addr 3 -> err=1.
- Assert rst_n=0 in the COMMIT cycle of a WRITE addr 0 data 0xA5A5A5A5 -> no resp_valid; reg_bank[0]=0; lock_status=0; next grant goes to requester 0.
